box_draw_scheduler: RTL and testbench
=====================================

// Module: box_draw_scheduler
// PURPOSE
//  Shares the single box-draw engine (start_x/y, x/y_size, draw pulse, done level) between two box
//  requesters and a clear-screen request. Latches one command per grant, clips it to the screen,
//  fires the engine's one-cycle go and waits for completion. Sits between the user-input controllers
//  and the box-draw engine that drives the VGA pixel port.
// PARAMETERS
//  X_SCREEN_PIXELS  8'd160    screen width; clear-screen width; clip limit for x
//  Y_SCREEN_PIXELS  7'd120    screen height; clear-screen height; clip limit for y
//  TIMEOUT          16'd20000 max cycles in S_WAIT_HIGH before abort
// PORTS
//  iClock       in   1  clock, all logic on posedge
//  iResetn      in   1  reset, synchronous, active-low
//  iReq0/iReq1  in   1  requester n has a command; hold with fields stable until oAckN
//  iX0/iX1      in   8  box start x
//  iY0/iY1      in   7  box start y
//  iW0/iW1      in   8  box width (pixels)
//  iH0/iH1      in   7  box height (pixels)
//  iCol0/iCol1  in   3  box colour
//  iClear       in   1  clear-screen request (black, 0,0, full screen); hold until oAckClr
//  iEngineDone  in   1  engine done level (stays high after finishing until next go)
//  oAck0/oAck1/oAckClr out 1  one-cycle pulse: command latched
//  oGo          out  1  one-cycle pulse to engine draw input
//  oStartX 8, oStartY 7, oSizeX 8, oSizeY 7, oColour 3   out  latched command to engine
//  oGrant       out  2  0=req0, 1=req1, 2=clear, 3=none
//  oBusy        out  1  high in every state except S_IDLE
//  oCmdDone     out  1  one-cycle pulse when engine completes a command
//  oTimeout     out  1  sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (iResetn=0 at edge): state S_IDLE; all outputs 0 except oGrant=3; rr pointer=0 (req0 favoured);
//   timeout counter 0. Reset mid-draw aborts immediately; no oCmdDone.
//  States: S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_DONE. All outputs registered.
//  S_IDLE: arbitrate every cycle. iClear beats both boxes. Between iReq0/iReq1, round robin:
//   pointer names the favoured requester; after serving N, pointer = other one.
//   On grant: latch fields, set oGrant, pulse ack. Go to S_ISSUE.
//   Zero W or H, X>=X_SCREEN_PIXELS, or Y>=Y_SCREEN_PIXELS: ack, drop, stay S_IDLE.
//   Dropped command: no oGo, no oCmdDone; pointer still advances.
//  Clip: oSizeX = min(W, X_SCREEN_PIXELS-X); oSizeY = min(H, Y_SCREEN_PIXELS-Y).
//   Compute in 9/8-bit to avoid wrap.
//  Clear: oStartX=0, oStartY=0, oSizeX=X_SCREEN_PIXELS, oSizeY=Y_SCREEN_PIXELS, oColour=0.
//  S_ISSUE (1 cycle): oGo=1; command outputs stable from here until next grant. Go to S_WAIT_LOW.
//  S_WAIT_LOW: wait for iEngineDone=0, which rejects the stale done level from the prior command.
//   Then go to S_WAIT_HIGH and clear the counter.
//  S_WAIT_HIGH: counter++ each cycle.
//   iEngineDone=1 -> S_DONE.
//   Counter reaches TIMEOUT-1 -> oTimeout=1, go to S_IDLE without oCmdDone.
//   Counter also runs in S_WAIT_LOW, so an engine stuck high also aborts.
//  S_DONE (1 cycle): oCmdDone=1, oGrant=3. Go to S_IDLE.
//  Latency: request seen in IDLE at edge n -> oAck at n+1, oGo at n+2.
//   Best-case completion to next grant: 2 cycles.
//  Requests arriving while busy are held off (no ack) and are not lost while held.
//  A requester still asserting iReq in S_IDLE after its command completes is treated as a new command.
//  Simultaneous iReq0, iReq1, iClear: clear first, then the favoured box, then the other.
// TESTING
//  1. Reset, iReq0 X=10 Y=20 W=4 H=4 col=3; model engine done after 16 cycles
//     -> oAck0 at +1, oGo at +2 with 10/20/4/4/3, one oCmdDone.
//  2. iReq0 and iReq1 held high continuously -> grants alternate 0,1,0,1; each ack exactly once per command.
//  3. iClear with iReq0 and iReq1 all high -> clear first: go with 0/0/160/120/0; then req0, then req1.
//  4. X=158 W=10, Y=118 H=5 -> oSizeX=2, oSizeY=2.
//     W=0 or X=160 -> ack only; no oGo, no oCmdDone.
//  5. Engine never raises done; TIMEOUT=50 -> oTimeout=1 after 50 wait cycles, return to IDLE,
//     next request still served.
//  6. Reset asserted mid-S_WAIT_HIGH -> next cycle all outputs at reset values, no oCmdDone.

Source files
------------

// File: rtl/box_draw_scheduler_if.sv
// Command/engine bus between the requesters, the box-draw scheduler and the box-draw engine.
// master = requester/engine side, slave = scheduler.
interface box_draw_scheduler_if;
  logic       iReq0, iReq1, iClear;
  logic [7:0] iX0, iX1, iW0, iW1;
  logic [6:0] iY0, iY1, iH0, iH1;
  logic [2:0] iCol0, iCol1;
  logic       iEngineDone;
  logic       oAck0, oAck1, oAckClr, oGo;
  logic [7:0] oStartX, oSizeX;
  logic [6:0] oStartY, oSizeY;
  logic [2:0] oColour;
  logic [1:0] oGrant;
  logic       oBusy, oCmdDone, oTimeout;

  modport master (
    output iReq0, iReq1, iClear, iX0, iX1, iW0, iW1, iY0, iY1, iH0, iH1, iCol0, iCol1, iEngineDone,
    input  oAck0, oAck1, oAckClr, oGo, oStartX, oSizeX, oStartY, oSizeY, oColour,
           oGrant, oBusy, oCmdDone, oTimeout
  );
  modport slave (
    input  iReq0, iReq1, iClear, iX0, iX1, iW0, iW1, iY0, iY1, iH0, iH1, iCol0, iCol1, iEngineDone,
    output oAck0, oAck1, oAckClr, oGo, oStartX, oSizeX, oStartY, oSizeY, oColour,
           oGrant, oBusy, oCmdDone, oTimeout
  );
endinterface

// File: rtl/box_draw_scheduler.sv
// Arbitrates two box requesters and a clear-screen request onto one box-draw engine,
// clipping each box to the screen and supervising the engine's done handshake.
module box_draw_scheduler #(
  parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120,
  parameter logic [15:0] TIMEOUT         = 16'd20000
) (
  input logic                  iClock,
  input logic                  iResetn,
  box_draw_scheduler_if.slave  bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [1:0] G_REQ0 = 2'd0;
  localparam logic [1:0] G_REQ1 = 2'd1;
  localparam logic [1:0] G_CLR  = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  logic [2:0]  state;
  logic        rr;          // 0: req0 favoured, 1: req1 favoured
  logic [15:0] cnt;

  logic        pick1, box_ok, cnt_expired;
  logic [7:0]  bx, bw, clip_x;
  logic [6:0]  by, bh, clip_y;
  logic [2:0]  bc;
  logic [8:0]  rem_x;
  logic [7:0]  rem_y;

  // Box candidate and its screen clip; the remaining span is formed one bit wider so it cannot wrap.
  always_comb begin
    pick1       = bus.iReq1 && (!bus.iReq0 || rr);
    bx          = pick1 ? bus.iX1   : bus.iX0;
    by          = pick1 ? bus.iY1   : bus.iY0;
    bw          = pick1 ? bus.iW1   : bus.iW0;
    bh          = pick1 ? bus.iH1   : bus.iH0;
    bc          = pick1 ? bus.iCol1 : bus.iCol0;
    rem_x       = {1'b0, X_SCREEN_PIXELS} - {1'b0, bx};
    rem_y       = {1'b0, Y_SCREEN_PIXELS} - {1'b0, by};
    box_ok      = (bw != 8'd0) && (bh != 7'd0) && (bx < X_SCREEN_PIXELS) && (by < Y_SCREEN_PIXELS);
    clip_x      = ({1'b0, bw} < rem_x) ? bw : rem_x[7:0];
    clip_y      = ({1'b0, bh} < rem_y) ? bh : rem_y[6:0];
    cnt_expired = (cnt == TIMEOUT - 16'd1);
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state        <= S_IDLE;
      rr           <= 1'b0;
      cnt          <= 16'd0;
      bus.oAck0    <= 1'b0;
      bus.oAck1    <= 1'b0;
      bus.oAckClr  <= 1'b0;
      bus.oGo      <= 1'b0;
      bus.oStartX  <= 8'd0;
      bus.oStartY  <= 7'd0;
      bus.oSizeX   <= 8'd0;
      bus.oSizeY   <= 7'd0;
      bus.oColour  <= 3'd0;
      bus.oGrant   <= G_NONE;
      bus.oBusy    <= 1'b0;
      bus.oCmdDone <= 1'b0;
      bus.oTimeout <= 1'b0;
    end else begin
      bus.oAck0    <= 1'b0;
      bus.oAck1    <= 1'b0;
      bus.oAckClr  <= 1'b0;
      bus.oGo      <= 1'b0;
      bus.oCmdDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.iClear) begin
            bus.oAckClr <= 1'b1;
            bus.oStartX <= 8'd0;
            bus.oStartY <= 7'd0;
            bus.oSizeX  <= X_SCREEN_PIXELS;
            bus.oSizeY  <= Y_SCREEN_PIXELS;
            bus.oColour <= 3'd0;
            bus.oGrant  <= G_CLR;
            bus.oBusy   <= 1'b1;
            state       <= S_ISSUE;
          end else if (bus.iReq0 || bus.iReq1) begin
            // Off-screen or empty boxes are acknowledged and discarded, but still use up the turn.
            bus.oAck0 <= !pick1;
            bus.oAck1 <= pick1;
            rr        <= !pick1;
            if (box_ok) begin
              bus.oStartX <= bx;
              bus.oStartY <= by;
              bus.oSizeX  <= clip_x;
              bus.oSizeY  <= clip_y;
              bus.oColour <= bc;
              bus.oGrant  <= pick1 ? G_REQ1 : G_REQ0;
              bus.oBusy   <= 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          bus.oGo <= 1'b1;
          cnt     <= 16'd0;
          state   <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // The done level from the previous command must drop before a new rise means anything.
          if (!bus.iEngineDone) begin
            cnt   <= 16'd0;
            state <= S_WAIT_HIGH;
          end else if (cnt_expired) begin
            bus.oTimeout <= 1'b1;
            bus.oGrant   <= G_NONE;
            bus.oBusy    <= 1'b0;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.iEngineDone) begin
            bus.oCmdDone <= 1'b1;
            bus.oGrant   <= G_NONE;
            state        <= S_DONE;
          end else if (cnt_expired) begin
            bus.oTimeout <= 1'b1;
            bus.oGrant   <= G_NONE;
            bus.oBusy    <= 1'b0;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          bus.oBusy <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          bus.oGrant <= G_NONE;
          bus.oBusy  <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_box_draw_scheduler.sv
// Bench for box_draw_scheduler: directed vectors and sequences, then random traffic against a
// request-level model (priority, round robin, clip rules) with a behavioural engine.
module tb_box_draw_scheduler;
  localparam int TMO = 50;

  logic iClock  = 1'b0;
  logic iResetn = 1'b0;
  box_draw_scheduler_if bus();

  box_draw_scheduler #(.X_SCREEN_PIXELS(8'd160), .Y_SCREEN_PIXELS(7'd120), .TIMEOUT(16'(TMO)))
    dut (.iClock(iClock), .iResetn(iResetn), .bus(bus));

  always #5 iClock = ~iClock;

  // Engine: drops done the cycle after go, raises it again after a latency unless hung.
  logic eng_hang = 1'b0;
  logic eng_rand = 1'b0;
  int   eng_cnt;
  always @(posedge iClock) begin
    if (!iResetn) begin
      bus.iEngineDone <= 1'b1;
      eng_cnt         <= 0;
    end else if (bus.oGo) begin
      bus.iEngineDone <= 1'b0;
      eng_cnt         <= eng_rand ? int'($urandom_range(12, 1)) : 16;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hang) bus.iEngineDone <= 1'b1;
    end
  end

  typedef struct { int x; int y; int w; int h; int c; int ok; int sx; int sy; } vec_t;
  vec_t tbl[8];

  int n_total = 0;
  int n_pass  = 0;
  int ptr     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int acks();
    return int'({bus.oAckClr, bus.oAck1, bus.oAck0});
  endfunction

  function automatic void model_box(input int x, y, w, h, output int ok, output int sx, output int sy);
    ok = (w != 0 && h != 0 && x < 160 && y < 120) ? 1 : 0;
    sx = (w < 160 - x) ? w : 160 - x;
    sy = (h < 120 - y) ? h : 120 - y;
  endfunction

  task automatic drive(input int which, input int x, y, w, h, c);
    if (which == 0) begin
      bus.iX0 = 8'(x); bus.iY0 = 7'(y); bus.iW0 = 8'(w); bus.iH0 = 7'(h); bus.iCol0 = 3'(c); bus.iReq0 = 1'b1;
    end else begin
      bus.iX1 = 8'(x); bus.iY1 = 7'(y); bus.iW1 = 8'(w); bus.iH1 = 7'(h); bus.iCol1 = 3'(c); bus.iReq1 = 1'b1;
    end
  endtask

  task automatic drop_acked(input int a);
    if (a[0]) bus.iReq0 = 1'b0;
    if (a[1]) bus.iReq1 = 1'b0;
    if (a[2]) bus.iClear = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input int x, y, sx, sy, c);
    chk({tag, "_startx"}, int'(bus.oStartX), x);
    chk({tag, "_starty"}, int'(bus.oStartY), y);
    chk({tag, "_sizex"},  int'(bus.oSizeX),  sx);
    chk({tag, "_sizey"},  int'(bus.oSizeY),  sy);
    chk({tag, "_colour"}, int'(bus.oColour), c);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!bus.oBusy) break;
      @(negedge iClock);
    end
    chk(tag, int'(bus.oBusy), 0);
  endtask

  // One command from an idle scheduler: ack after one cycle, go the cycle after, one done.
  task automatic run_box(input string tag, input int which, input int x, y, w, h, c, ok, sx, sy);
    int nd, ng;
    @(negedge iClock);
    drive(which, x, y, w, h, c);
    @(negedge iClock);
    chk({tag, "_ack"}, acks(), 1 << which);
    drop_acked(acks());
    ptr = 1 - which;
    @(negedge iClock);
    chk({tag, "_go"}, int'(bus.oGo), ok);
    if (ok != 0) begin
      chk_cmd(tag, x, y, sx, sy, c);
      chk({tag, "_grant"}, int'(bus.oGrant), which);
    end
    nd = 0; ng = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClock);
      if (bus.oCmdDone) begin
        nd++;
        chk({tag, "_grant_at_done"}, int'(bus.oGrant), 3);
      end
      if (bus.oGo) ng++;
    end
    chk({tag, "_cmd_done_count"}, nd, ok);
    chk({tag, "_extra_go"}, ng, 0);
    chk({tag, "_idle_after"}, int'(bus.oBusy), 0);
  endtask

  initial begin
    int a, ea, dbl, pa, t, cd, n_valid, n_done, w, ok, sx, sy, ex_go, ex_x, ex_y, ex_sx, ex_sy, ex_c;
    int order[$];
    logic prev_busy, exp_clr;

    tbl[0] = '{x:158, y:118, w:10,  h:5,   c:6, ok:1, sx:2,   sy:2};
    tbl[1] = '{x:0,   y:0,   w:160, h:120, c:1, ok:1, sx:160, sy:120};
    tbl[2] = '{x:10,  y:20,  w:0,   h:5,   c:2, ok:0, sx:0,   sy:0};
    tbl[3] = '{x:160, y:5,   w:4,   h:4,   c:2, ok:0, sx:0,   sy:0};
    tbl[4] = '{x:159, y:119, w:1,   h:1,   c:7, ok:1, sx:1,   sy:1};
    tbl[5] = '{x:100, y:50,  w:255, h:127, c:5, ok:1, sx:60,  sy:70};
    tbl[6] = '{x:5,   y:120, w:4,   h:4,   c:2, ok:0, sx:0,   sy:0};
    tbl[7] = '{x:20,  y:100, w:3,   h:0,   c:1, ok:0, sx:0,   sy:0};

    bus.iReq0 = 0; bus.iReq1 = 0; bus.iClear = 0;
    bus.iX0 = 0; bus.iY0 = 0; bus.iW0 = 0; bus.iH0 = 0; bus.iCol0 = 0;
    bus.iX1 = 0; bus.iY1 = 0; bus.iW1 = 0; bus.iH1 = 0; bus.iCol1 = 0;

    // Reset state
    repeat (3) @(negedge iClock);
    chk("rst_acks", acks(), 0);
    chk("rst_go", int'(bus.oGo), 0);
    chk("rst_grant", int'(bus.oGrant), 3);
    chk("rst_busy", int'(bus.oBusy), 0);
    chk("rst_timeout", int'(bus.oTimeout), 0);
    chk_cmd("rst", 0, 0, 0, 0, 0);
    iResetn = 1'b1;

    // Single box, then the clip/drop table alternating requesters
    run_box("basic", 0, 10, 20, 4, 4, 3, 1, 4, 4);
    for (int i = 0; i < 8; i++)
      run_box($sformatf("vec%0d", i), i % 2, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c,
              tbl[i].ok, tbl[i].sx, tbl[i].sy);

    // Both requesters held: grants must alternate, one ack per command
    @(negedge iClock);
    drive(0, 1, 1, 5, 5, 1);
    drive(1, 2, 2, 6, 6, 2);
    order.delete(); dbl = 0; pa = 0;
    for (int i = 0; i < 400 && order.size() < 4; i++) begin
      @(negedge iClock);
      a = acks();
      if (a != 0 && pa != 0) dbl++;
      pa = a;
      if (a != 0) order.push_back(a);
    end
    bus.iReq0 = 0; bus.iReq1 = 0;
    chk("rr_ack_count", order.size(), 4);
    chk("rr_back_to_back", dbl, 0);
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("rr_order%0d", i), order[i], 1 << ptr);
      ptr = 1 - ptr;
    end
    wait_idle("rr_idle");

    // Clear plus both boxes at once: clear, favoured box, other box
    @(negedge iClock);
    drive(0, 3, 3, 2, 2, 4);
    drive(1, 4, 4, 2, 2, 5);
    bus.iClear = 1'b1;
    order.delete(); exp_clr = 0;
    for (int i = 0; i < 400 && order.size() < 3; i++) begin
      @(negedge iClock);
      if (exp_clr) begin
        chk("clr_go", int'(bus.oGo), 1);
        chk_cmd("clr", 0, 0, 160, 120, 0);
        chk("clr_grant", int'(bus.oGrant), 2);
        exp_clr = 0;
      end
      a = acks();
      if (a == 4) exp_clr = 1;
      if (a != 0) begin order.push_back(a); drop_acked(a); end
    end
    chk("prio_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("prio_first", order[0], 4);
      chk("prio_second", order[1], 1 << ptr);
      chk("prio_third", order[2], 1 << (1 - ptr));
    end
    wait_idle("prio_idle");

    // Hung engine: abort after TMO cycles of waiting, sticky flag, next request still served
    eng_hang = 1'b1;
    @(negedge iClock);
    drive(0, 30, 30, 8, 8, 2);
    @(negedge iClock);
    chk("tmo_ack", acks(), 1);
    drop_acked(acks());
    ptr = 1;
    @(negedge iClock);
    chk("tmo_go", int'(bus.oGo), 1);
    t = 0; cd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClock);
      t++;
      if (bus.oCmdDone) cd++;
      if (bus.oTimeout) break;
    end
    // done drops one edge after go, seen low one edge later, then TMO cycles of waiting
    chk("tmo_latency", t, TMO + 2);
    chk("tmo_no_done", cd, 0);
    chk("tmo_busy", int'(bus.oBusy), 0);
    chk("tmo_grant", int'(bus.oGrant), 3);
    eng_hang = 1'b0;
    run_box("after_tmo", 1, 40, 40, 3, 3, 6, 1, 3, 3);
    chk("tmo_sticky", int'(bus.oTimeout), 1);

    // Reset in the middle of a draw
    @(negedge iClock);
    drive(0, 50, 60, 10, 10, 3);
    @(negedge iClock);
    drop_acked(acks());
    @(negedge iClock);
    chk("mid_go", int'(bus.oGo), 1);
    repeat (6) @(negedge iClock);
    iResetn = 1'b0;
    @(negedge iClock);
    chk("mid_rst_acks", acks(), 0);
    chk("mid_rst_go", int'(bus.oGo), 0);
    chk("mid_rst_done", int'(bus.oCmdDone), 0);
    chk("mid_rst_busy", int'(bus.oBusy), 0);
    chk("mid_rst_grant", int'(bus.oGrant), 3);
    chk("mid_rst_timeout", int'(bus.oTimeout), 0);
    chk_cmd("mid_rst", 0, 0, 0, 0, 0);
    iResetn = 1'b1;
    ptr = 0;
    cd = 0;
    repeat (30) begin
      @(negedge iClock);
      if (bus.oCmdDone) cd++;
    end
    chk("mid_rst_no_done", cd, 0);

    // Random traffic against the request-level model
    eng_rand = 1'b1;
    n_valid = 0; n_done = 0; ex_go = 0;
    ex_x = 0; ex_y = 0; ex_sx = 0; ex_sy = 0; ex_c = 0;
    prev_busy = bus.oBusy;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge iClock);
      a  = acks();
      ea = 0;
      if (!prev_busy) begin
        if (bus.iClear) ea = 4;
        else if (bus.iReq0 && bus.iReq1) ea = 1 << ptr;
        else if (bus.iReq0) ea = 1;
        else if (bus.iReq1) ea = 2;
      end
      chk("rand_ack", a, ea);
      chk("rand_go", int'(bus.oGo), ex_go);
      if (ex_go != 0 && bus.oGo) chk_cmd("rand", ex_x, ex_y, ex_sx, ex_sy, ex_c);
      ex_go = 0;
      if (bus.oCmdDone) begin
        n_done++;
        chk("rand_done_grant", int'(bus.oGrant), 3);
      end
      if (ea != 0) begin
        if (ea == 4) begin
          ok = 1; ex_x = 0; ex_y = 0; ex_sx = 160; ex_sy = 120; ex_c = 0; w = 2;
        end else begin
          w = (ea == 1) ? 0 : 1;
          if (w == 0) begin
            model_box(int'(bus.iX0), int'(bus.iY0), int'(bus.iW0), int'(bus.iH0), ok, sx, sy);
            ex_x = int'(bus.iX0); ex_y = int'(bus.iY0); ex_c = int'(bus.iCol0);
          end else begin
            model_box(int'(bus.iX1), int'(bus.iY1), int'(bus.iW1), int'(bus.iH1), ok, sx, sy);
            ex_x = int'(bus.iX1); ex_y = int'(bus.iY1); ex_c = int'(bus.iCol1);
          end
          ex_sx = sx; ex_sy = sy;
          ptr = 1 - w;
        end
        chk("rand_busy", int'(bus.oBusy), ok);
        if (ok != 0) begin
          chk("rand_grant", int'(bus.oGrant), w);
          ex_go = 1;
          n_valid++;
        end
      end
      drop_acked(a);
      for (int r = 0; r < 2; r++) begin
        if (((r == 0) ? !bus.iReq0 : !bus.iReq1) && $urandom_range(3, 0) == 0)
          drive(r, int'($urandom_range(175, 0)), int'($urandom_range(127, 0)),
                ($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : int'($urandom_range(30, 0)),
                ($urandom_range(1, 0) == 1) ? int'($urandom_range(127, 0)) : int'($urandom_range(30, 0)),
                int'($urandom_range(7, 0)));
      end
      if (!bus.iClear && $urandom_range(40, 0) == 0) bus.iClear = 1'b1;
      prev_busy = bus.oBusy;
    end
    bus.iReq0 = 0; bus.iReq1 = 0; bus.iClear = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iClock);
      if (bus.oCmdDone) n_done++;
    end
    chk("rand_done_count", n_done, n_valid);
    chk("rand_idle", int'(bus.oBusy), 0);
    chk("rand_no_timeout", int'(bus.oTimeout), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
